generador_tono: RTL and testbench
=================================

// Module: generador_tono
// PURPOSE
// Square-wave tone generator downstream of the microcontroller core. Consumes the
// 25-bit half-period word and its load strobe (contador / s_cont outputs of the core)
// and drives a 50%-duty output pin (buzzer/LED), optionally for a fixed number of full
// periods. It reports busy/done status so the program can poll it through an input port.
// PARAMETERS
// WIDTH       25  width of half-period word and internal down-counter
// DUR_W       8   width of the duration (full-period count) field
// MIN_PERIOD  2   smallest accepted half-period; smaller values are treated as "silence"
// PORTS
// clk        in   1       system clock, all state updates on rising edge
// reset      in   1       asynchronous, active-high reset
// load       in   1       strobe: latch period/dur and (re)start tone (driven by s_cont)
// stop       in   1       synchronous abort: silence output, return to IDLE
// period     in   WIDTH   half-period in clk cycles (driven by contador)
// dur        in   DUR_W   number of full periods to play; 0 = play until stop/load
// tone_out   out  1       square-wave output
// busy       out  1       1 while in RUN
// done       out  1       one-cycle pulse when a finite duration completes
// BEHAVIOUR
// - Reset (async, active-high): state=IDLE, tone_out=0, busy=0, done=0, counter=0,
//   latched period=0, remaining=0. Reset mid-tone aborts immediately, no done pulse.
// - FSM states: IDLE, RUN. All outputs registered; busy = (state==RUN).
// - Priority at a clock edge: stop > load > normal counting.
// - stop=1: next state IDLE, tone_out=0, done=0, regardless of load.
// - load=1 (stop=0), any state: latch P=period, R=dur.
//   * P < MIN_PERIOD: next state IDLE, tone_out=0, no done.
//   * else: next state RUN, tone_out=1, counter=P-1. A load in RUN restarts cleanly.
// - RUN, no load/stop, counter!=0: counter decrements by 1; tone_out holds.
// - RUN, counter==0: tone_out toggles, counter reloads to P-1.
//   * Toggle 1->0 ends the high half; toggle 0->1 completes a full period.
//   * On a 0->1 boundary with R!=0: if R==1 -> go IDLE, tone_out stays 0, done=1 for
//     exactly one cycle; else R decrements. With R==0 (continuous) R never changes.
// - Result: tone_out high exactly P cycles then low exactly P cycles; first rising edge
//   of tone_out is registered at the edge where load is sampled (latency 1 cycle).
// - Finite tone of dur=N ends after exactly 2*P*N cycles; busy falls together with done.
// - period changes without load are ignored (only latched value used).
// - IDLE with no load: all outputs held low, counter frozen.
// - Counter arithmetic is unsigned WIDTH bits; P-1 never underflows since P>=MIN_PERIOD.
// TESTING
// - Reset: assert reset mid-RUN with tone_out=1 -> tone_out=0, busy=0, done=0 same
//   cycle (async), stays IDLE after release with no load.
// - Continuous: period=4, dur=0, pulse load -> tone_out 1 for 4 cycles, 0 for 4,
//   repeating; busy=1 throughout; done never asserts over 100 cycles.
// - Finite: period=3, dur=2, pulse load -> 12 cycles of 1,1,1,0,0,0 pattern, then
//   done=1 for one cycle, busy=0, tone_out=0 thereafter.
// - Silence: period=1 (and period=0) with load -> stays/returns IDLE, tone_out=0,
//   busy=0, no done.
// - Restart: period=10 running, at cycle 5 load period=2 -> tone_out=1 next cycle,
//   then 2-high/2-low pattern; old period never observed again.
// - Simultaneous: load=1 and stop=1 same cycle while RUN -> IDLE, tone_out=0, no
//   restart; stop while IDLE -> no effect.

Source files
------------

// File: rtl/generador_tono_if.sv
// generador_tono_if
// Bundles the control and status signals between the microcontroller core and the
// square-wave tone generator.
//
// Signals
//   load      core -> gen  strobe that latches period/dur and (re)starts the tone
//   stop      core -> gen  synchronous abort, silences the output
//   period    core -> gen  half-period in clock cycles
//   dur       core -> gen  number of full periods to play, 0 = continuous
//   tone_out  gen -> core  square-wave output pin
//   busy      gen -> core  high while a tone is playing
//   done      gen -> core  one-cycle pulse when a finite tone completes
//
// Modports
//   master  the side that issues commands (core or testbench)
//   slave   the tone generator itself
interface generador_tono_if #(
   parameter int WIDTH = 25,
   parameter int DUR_W = 8
);

   logic             load;
   logic             stop;
   logic [WIDTH-1:0] period;
   logic [DUR_W-1:0] dur;
   logic             tone_out;
   logic             busy;
   logic             done;

   modport master (
      output load,
      output stop,
      output period,
      output dur,
      input  tone_out,
      input  busy,
      input  done
   );

   modport slave (
      input  load,
      input  stop,
      input  period,
      input  dur,
      output tone_out,
      output busy,
      output done
   );

endinterface

// File: rtl/generador_tono.sv
// generador_tono
// Square-wave tone generator. A load strobe latches a half-period P and a duration N
// (in full periods). The output then goes high for P cycles and low for P cycles,
// repeating forever when N is 0, or N times followed by a one-cycle done pulse.
// Half-periods below MIN_PERIOD are treated as a request for silence.
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    generador_tono_if slave modport (load/stop/period/dur in,
//          tone_out/busy/done out)
//
// All outputs come straight from flops: tone_out and done are their own registers,
// and busy is a decode of the state register.
module generador_tono #(
   parameter int WIDTH      = 25,
   parameter int DUR_W      = 8,
   parameter int MIN_PERIOD = 2
) (
   input  logic             clk,
   input  logic             reset,
   generador_tono_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] MIN_P     = WIDTH'(MIN_PERIOD);
   localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
   localparam logic [DUR_W-1:0] ONE_D     = DUR_W'(1);
   localparam logic [WIDTH-1:0] ZERO_W    = '0;
   localparam logic [DUR_W-1:0] ZERO_D    = '0;

   state_t           state;
   logic             tone_q;
   logic             done_q;
   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] period_q;
   logic [DUR_W-1:0] remaining;

   // Whole controller in one sequential block. Priority is stop, then load, then
   // normal counting. The counter counts down the current half-period; when it
   // reaches zero the output flips and the counter reloads. A low-to-high flip marks
   // the end of one full period, which is where the duration bookkeeping happens.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tone_q    <= 1'b0;
         done_q    <= 1'b0;
         counter   <= ZERO_W;
         period_q  <= ZERO_W;
         remaining <= ZERO_D;
      end else if (bus.stop) begin
         state  <= IDLE;
         tone_q <= 1'b0;
         done_q <= 1'b0;
      end else if (bus.load) begin
         period_q  <= bus.period;
         remaining <= bus.dur;
         done_q    <= 1'b0;
         if (bus.period < MIN_P) begin
            state  <= IDLE;
            tone_q <= 1'b0;
         end else begin
            // The first high half starts right at this edge, so the counter
            // covers the remaining P-1 cycles of it.
            state   <= RUN;
            tone_q  <= 1'b1;
            counter <= bus.period - ONE_W;
         end
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               tone_q <= 1'b0;
            end
            RUN: begin
               if (counter != ZERO_W) begin
                  counter <= counter - ONE_W;
               end else begin
                  counter <= period_q - ONE_W;
                  if (tone_q) begin
                     tone_q <= 1'b0;
                  end else if (remaining == ONE_D) begin
                     // Last full period just finished: stay low and report.
                     state     <= IDLE;
                     tone_q    <= 1'b0;
                     done_q    <= 1'b1;
                     remaining <= ZERO_D;
                  end else begin
                     // A zero count means continuous play and is never touched.
                     tone_q <= 1'b1;
                     if (remaining != ZERO_D) begin
                        remaining <= remaining - ONE_D;
                     end
                  end
               end
            end
            default: begin
               state  <= IDLE;
               tone_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tone_out = tone_q;
   assign bus.done     = done_q;
   assign bus.busy     = (state == RUN);

endmodule

// File: tb/tb_generador_tono.sv
// tb_generador_tono
// Self-checking bench for generador_tono. A behavioural model tracks, for the tone
// currently playing, how many cycles have elapsed since its load edge; the expected
// output follows directly from that count and the latched P and N. A compare process
// checks every cycle outside reset, and directed sequences pin literal waveforms.
module tb_generador_tono;

   localparam int WIDTH = 25;
   localparam int DUR_W = 8;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   generador_tono_if #(.WIDTH(WIDTH), .DUR_W(DUR_W)) bus ();

   generador_tono #(.WIDTH(WIDTH), .DUR_W(DUR_W), .MIN_PERIOD(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: is a tone playing, its P and N, and cycles since load.
   logic   m_active;
   longint m_p;
   longint m_n;
   longint m_k;
   logic   exp_tone;
   logic   exp_busy;
   logic   exp_done;

   // Model update on each clock edge using the inputs the DUT sees at that edge.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_active = 1'b0;
         m_k      = 0;
         exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (bus.stop) begin
            m_active = 1'b0;
         end else if (bus.load) begin
            if (bus.period < 2) begin
               m_active = 1'b0;
            end else begin
               m_active = 1'b1;
               m_p      = longint'(bus.period);
               m_n      = longint'(bus.dur);
               m_k      = 0;
            end
         end else if (m_active) begin
            m_k = m_k + 1;
            if (m_n != 0 && m_k == 2 * m_p * m_n) begin
               m_active = 1'b0;
               exp_done = 1'b1;
            end
         end
      end
      exp_busy = m_active;
      exp_tone = m_active && (((m_k / m_p) % 2) == 0);
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         checkOutput("model_tone", longint'(bus.tone_out), longint'(exp_tone));
         checkOutput("model_busy", longint'(bus.busy), longint'(exp_busy));
         checkOutput("model_done", longint'(bus.done), longint'(exp_done));
      end
   end

   // Drive one cycle of inputs at the falling edge.
   task automatic applyStimulus(input logic ld, input logic st, input int per, input int du);
      @(negedge clk);
      bus.load   = ld;
      bus.stop   = st;
      bus.period = WIDTH'(per);
      bus.dur    = DUR_W'(du);
   endtask

   // Pulse load and capture tone_out for n samples, starting at the load edge.
   task automatic captureTone(input int per, input int du, input int n, output logic [63:0] bits,
                              output int done_cnt);
      bits     = '0;
      done_cnt = 0;
      applyStimulus(1'b1, 1'b0, per, du);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
         bus.load = 1'b0;
         bits[n-1-i] = bus.tone_out;
         if (bus.done) done_cnt++;
      end
   endtask

   logic [63:0] cap;
   int          dcnt;

   initial begin
      reset      = 1'b1;
      bus.load   = 1'b0;
      bus.stop   = 1'b0;
      bus.period = '0;
      bus.dur    = '0;
      #12;
      checkOutput("reset_tone", longint'(bus.tone_out), 0);
      checkOutput("reset_busy", longint'(bus.busy), 0);
      checkOutput("reset_done", longint'(bus.done), 0);
      @(negedge clk);
      reset = 1'b0;

      // Continuous P=4: 4 high, 4 low, repeating.
      captureTone(4, 0, 16, cap, dcnt);
      checkOutput("cont_p4_pattern", longint'(cap[15:0]), longint'(16'hF0F0));
      dcnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (bus.done || !bus.busy) dcnt++;
      end
      checkOutput("cont_100_no_done_busy", dcnt, 0);
      applyStimulus(1'b0, 1'b1, 0, 0);

      // Finite P=3 N=2: 12 cycles of 111000 then done and silence.
      applyStimulus(1'b0, 1'b0, 0, 0);
      captureTone(3, 2, 14, cap, dcnt);
      checkOutput("fin_p3n2_pattern", longint'(cap[13:0]), longint'(14'b11100011100000));
      checkOutput("fin_done_pulses", dcnt, 1);
      checkOutput("fin_busy_after", longint'(bus.busy), 0);

      // Silence requests.
      captureTone(1, 0, 3, cap, dcnt);
      checkOutput("silence_p1", longint'(cap[2:0]) + longint'(bus.busy), 0);
      captureTone(0, 3, 3, cap, dcnt);
      checkOutput("silence_p0", longint'(cap[2:0]) + longint'(bus.busy) + dcnt, 0);

      // Restart: P=10 running, reload with P=2 five cycles in.
      captureTone(10, 0, 5, cap, dcnt);
      checkOutput("restart_before", longint'(cap[4:0]), longint'(5'b11111));
      captureTone(2, 0, 8, cap, dcnt);
      checkOutput("restart_p2_pattern", longint'(cap[7:0]), longint'(8'b11001100));

      // load and stop together while running: stop wins.
      applyStimulus(1'b1, 1'b1, 5, 0);
      @(posedge clk);
      #2;
      checkOutput("load_stop_busy", longint'(bus.busy), 0);
      checkOutput("load_stop_tone", longint'(bus.tone_out), 0);
      // stop while idle has no visible effect.
      applyStimulus(1'b0, 1'b1, 5, 0);
      @(posedge clk);
      #2;
      checkOutput("stop_idle_busy", longint'(bus.busy), 0);
      applyStimulus(1'b0, 1'b0, 0, 0);

      // Asynchronous reset while the output is high.
      captureTone(6, 0, 3, cap, dcnt);
      checkOutput("pre_reset_tone", longint'(bus.tone_out), 1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_tone", longint'(bus.tone_out), 0);
      checkOutput("async_reset_busy", longint'(bus.busy), 0);
      checkOutput("async_reset_done", longint'(bus.done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("post_reset_idle", longint'(bus.busy) + longint'(bus.tone_out), 0);

      // Randomized traffic checked by the model; period wanders without load.
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         applyStimulus(r < 4, (r >= 4) && (r < 6), int'($urandom_range(0, 9)),
                       int'($urandom_range(0, 4)));
      end
      applyStimulus(1'b0, 1'b0, 0, 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
